calc_param_scheduler: RTL and testbench

- Shares one calc_new_parameters instance among NUM_AXES stepper-axis requesters using round-robin arbitration.
- Latches the granted axis's operand set and drives the calculator's start/finish handshake.
- Captures the five new_par words and returns them, tagged with the axis index, on a shared result bus.
- Sits between the per-axis motion planners and the single speed/jerk/acceleration calculator.

---
 rtl/calc_param_scheduler.sv | 172 +++++++++++++++++
 tb/tb_calc_param_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_param_scheduler.sv
// Purpose : round-robin share of one calc_new_parameters unit among NUM_AXES axis requesters.
// Latency : ack 1 cycle after req, calc_start 2, res_valid 4 (fast calculator), IDLE again after 6.
// Backpres: req is a level held until ack; no new grant until the calculator has dropped finish.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   req / ack            per-axis level request, one-cycle grant pulse (operands latched)
//   ax_params            per-axis params[0:4], axis i at [i*160+:160], word k at [k*32+:32]
//   ax_max_params        per-axis max_params[0:4], same packing
//   ax_max_timing        per-axis max_timing[0:3], axis i at [i*256+:256], word k at [k*64+:64]
//   calc_start           start to calculator, high only in START/WAIT
//   calc_params/...      latched operand set of the granted axis
//   calc_new_par/finish  calculator result and done flag
//   res_valid            one-cycle pulse; res_axis/res_data/res_err hold until the next pulse
//   res_err              calculation timed out, res_data forced to zero
//   busy                 high in every state except IDLE
module calc_param_scheduler #(
  parameter int NUM_AXES = 4,
  parameter int AXW      = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_AXES-1:0]   req,
  output logic [NUM_AXES-1:0]   ack,
  input  logic [NUM_AXES*160-1:0] ax_params,
  input  logic [NUM_AXES*160-1:0] ax_max_params,
  input  logic [NUM_AXES*256-1:0] ax_max_timing,
  output logic                  calc_start,
  output logic [159:0]          calc_params,
  output logic [159:0]          calc_max_params,
  output logic [255:0]          calc_max_timing,
  input  logic [159:0]          calc_new_par,
  input  logic                  calc_finish,
  output logic                  res_valid,
  output logic [AXW-1:0]        res_axis,
  output logic [159:0]          res_data,
  output logic                  res_err,
  output logic                  busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [AXW-1:0]    rr_ptr, rr_nxt;
  logic [AXW-1:0]    idx;
  logic [CW-1:0]     cnt, cnt_nxt;

  logic              grant_en;
  logic              found;
  logic [AXW-1:0]    grant_idx;
  logic [AXW-1:0]    cand;
  logic [NUM_AXES-1:0] ack_nxt;
  logic              start_nxt;
  logic              res_valid_nxt;
  logic [AXW-1:0]    res_axis_nxt;
  logic [159:0]      res_data_nxt;
  logic              res_err_nxt;

  always_comb begin
    state_nxt     = state;
    rr_nxt        = rr_ptr;
    cnt_nxt       = cnt;
    grant_en      = 1'b0;
    found         = 1'b0;
    grant_idx     = rr_ptr;
    cand          = '0;
    ack_nxt       = '0;
    start_nxt     = calc_start;
    res_valid_nxt = 1'b0;
    res_axis_nxt  = res_axis;
    res_data_nxt  = res_data;
    res_err_nxt   = res_err;

    // First set request at or after the rr pointer, wrapping modulo NUM_AXES.
    for (int i = 0; i < NUM_AXES; i++) begin
      cand = AXW'((32'(rr_ptr) + 32'(i)) % NUM_AXES);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end

    case (state)
      IDLE: begin
        start_nxt = 1'b0;
        // A finish still high belongs to the previous job; do not start over it.
        if (!calc_finish && found) begin
          grant_en           = 1'b1;
          ack_nxt[grant_idx] = 1'b1;
          state_nxt          = START;
        end
      end
      START: begin
        start_nxt = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (calc_finish) begin
          res_valid_nxt = 1'b1;
          res_axis_nxt  = idx;
          res_data_nxt  = calc_new_par;
          res_err_nxt   = 1'b0;
          start_nxt     = 1'b0;
          state_nxt     = RELEASE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // TIMEOUT-th cycle in WAIT without finish: abort with an error result.
          res_valid_nxt = 1'b1;
          res_axis_nxt  = idx;
          res_data_nxt  = '0;
          res_err_nxt   = 1'b1;
          start_nxt     = 1'b0;
          state_nxt     = RELEASE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RELEASE: begin
        start_nxt = 1'b0;
        if (!calc_finish) begin
          rr_nxt    = AXW'((32'(idx) + 32'd1) % NUM_AXES);
          state_nxt = IDLE;
        end
      end
      default: begin
        start_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      idx             <= '0;
      cnt             <= '0;
      ack             <= '0;
      calc_start      <= 1'b0;
      calc_params     <= '0;
      calc_max_params <= '0;
      calc_max_timing <= '0;
      res_valid       <= 1'b0;
      res_axis        <= '0;
      res_data        <= '0;
      res_err         <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      cnt        <= cnt_nxt;
      ack        <= ack_nxt;
      calc_start <= start_nxt;
      res_valid  <= res_valid_nxt;
      res_axis   <= res_axis_nxt;
      res_data   <= res_data_nxt;
      res_err    <= res_err_nxt;
      busy       <= (state_nxt != IDLE);
      // Operands are captured only at grant; later input changes are ignored.
      if (grant_en) begin
        idx             <= grant_idx;
        calc_params     <= ax_params[grant_idx*160 +: 160];
        calc_max_params <= ax_max_params[grant_idx*160 +: 160];
        calc_max_timing <= ax_max_timing[grant_idx*256 +: 256];
      end
    end
  end

endmodule

// File: tb/tb_calc_param_scheduler.sv
// Purpose : directed bench for calc_param_scheduler with a stand-in calculator model.
// Latency : calculator model raises finish one edge after it sees start, optionally holds it.
// Backpres: requests are driven as levels and dropped after their ack.
module tb_calc_param_scheduler;

  localparam int NUM_AXES = 4;
  localparam int AXW      = 2;
  localparam int TIMEOUT  = 64;

  logic                    clk;
  logic                    reset;
  logic [NUM_AXES-1:0]     req;
  logic [NUM_AXES-1:0]     ack;
  logic [NUM_AXES*160-1:0] ax_params;
  logic [NUM_AXES*160-1:0] ax_max_params;
  logic [NUM_AXES*256-1:0] ax_max_timing;
  logic                    calc_start;
  logic [159:0]            calc_params;
  logic [159:0]            calc_max_params;
  logic [255:0]            calc_max_timing;
  logic [159:0]            calc_new_par;
  logic                    calc_finish;
  logic                    res_valid;
  logic [AXW-1:0]          res_axis;
  logic [159:0]            res_data;
  logic                    res_err;
  logic                    busy;

  int passed = 0;
  int total  = 0;

  calc_param_scheduler #(.NUM_AXES(NUM_AXES), .AXW(AXW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack),
    .ax_params(ax_params), .ax_max_params(ax_max_params), .ax_max_timing(ax_max_timing),
    .calc_start(calc_start), .calc_params(calc_params), .calc_max_params(calc_max_params),
    .calc_max_timing(calc_max_timing), .calc_new_par(calc_new_par), .calc_finish(calc_finish),
    .res_valid(res_valid), .res_axis(res_axis), .res_data(res_data), .res_err(res_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in calculator: new_par = {mp[3], mp[2], mt[3][31:0], p[0], p[0]} (word4..word0).
  logic       mode_never = 1'b0;
  int         hold_extra = 0;
  int         extra_cnt  = 0;
  logic [159:0] model_f;
  assign model_f = {calc_max_params[96 +: 32], calc_max_params[64 +: 32],
                    calc_max_timing[192 +: 32], calc_params[0 +: 32], calc_params[0 +: 32]};
  initial begin
    calc_finish  = 1'b0;
    calc_new_par = '0;
  end
  always @(posedge clk) begin
    if (mode_never) begin
      calc_finish <= 1'b0;
    end else if (calc_start) begin
      calc_finish  <= 1'b1;
      calc_new_par <= model_f;
      extra_cnt    <= hold_extra;
    end else if (calc_finish && extra_cnt != 0) begin
      extra_cnt <= extra_cnt - 1;
    end else begin
      calc_finish <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  localparam logic [159:0] AX1_RES = {32'd22, 32'd11, 32'd33, 32'd99, 32'd99};
  localparam logic [159:0] AX2_RES = {32'd7, 32'd500, 32'd1000, 32'd1, 32'd1};
  localparam logic [159:0] AX2_PAR = {128'd0, 32'd1};

  int n;
  int overlap;
  logic [NUM_AXES-1:0] exp_ack;

  initial begin
    reset = 1'b0;
    req   = '0;
    ax_params     = '0;
    ax_max_params = '0;
    ax_max_timing = '0;
    // axis1
    ax_params[1*160 + 0*32 +: 32]     = 32'd99;
    ax_max_params[1*160 + 2*32 +: 32] = 32'd11;
    ax_max_params[1*160 + 3*32 +: 32] = 32'd22;
    ax_max_timing[1*256 + 3*64 +: 64] = 64'd33;
    // axis2
    ax_params[2*160 + 0*32 +: 32]     = 32'd1;
    ax_max_params[2*160 + 0*32 +: 32] = 32'd10;
    ax_max_params[2*160 + 1*32 +: 32] = 32'd2;
    ax_max_params[2*160 + 2*32 +: 32] = 32'd500;
    ax_max_params[2*160 + 3*32 +: 32] = 32'd7;
    ax_max_timing[2*256 + 3*64 +: 64] = 64'd1000;
    // axis3
    ax_params[3*160 + 0*32 +: 32]     = 32'd3;

    // Reset state
    #12;
    check("rst_ack", 256'(ack), 256'(0));
    check("rst_start", 256'(calc_start), 256'(0));
    check("rst_calc_ops", 256'(calc_params | calc_max_params | calc_max_timing[159:0]), 256'(0));
    check("rst_res", 256'({res_valid, res_err, res_axis}), 256'(0));
    check("rst_res_data", 256'(res_data), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    reset = 1'b1;
    tick;

    // Single request on axis0
    req = 4'b0001;
    tick;                                          // E0
    check("t1_ack", 256'(ack), 256'(4'b0001));
    check("t1_busy", 256'(busy), 256'(1));
    check("t1_start_early", 256'(calc_start), 256'(0));
    req = '0;
    tick;                                          // E1
    check("t1_start", 256'(calc_start), 256'(1));
    check("t1_ack_pulse", 256'(ack), 256'(0));
    tick;                                          // E2
    check("t1_vld_early", 256'(res_valid), 256'(0));
    tick;                                          // E3
    check("t1_vld", 256'(res_valid), 256'(1));
    check("t1_axis", 256'(res_axis), 256'(0));
    check("t1_data", 256'(res_data), 256'(0));
    check("t1_err", 256'(res_err), 256'(0));
    check("t1_start_drop", 256'(calc_start), 256'(0));
    tick;                                          // E4
    check("t1_vld_pulse", 256'(res_valid), 256'(0));
    check("t1_busy_rel", 256'(busy), 256'(1));
    tick;                                          // E5
    check("t1_idle", 256'(busy), 256'(0));

    // Operand routing from axis2; changes after ack must not leak in
    req = 4'b0100;
    tick;
    check("t2_ack", 256'(ack), 256'(4'b0100));
    check("t2_calc_params", 256'(calc_params), 256'(AX2_PAR));
    req = '0;
    ax_params[2*160 +: 32] = 32'd55;
    tick; tick; tick;
    check("t2_vld", 256'(res_valid), 256'(1));
    check("t2_axis", 256'(res_axis), 256'(2));
    check("t2_data", 256'(res_data), 256'(AX2_RES));
    tick; tick;
    check("t2_idle", 256'(busy), 256'(0));

    // Round-robin with all requests held, from a fresh pointer
    reset = 1'b0;
    #2;
    reset = 1'b1;
    req = 4'b1111;
    overlap = 0;
    for (int g = 0; g < 5; g++) begin
      exp_ack = 4'b0001 << (g % 4);
      n = 0;
      do begin
        tick; n++;
        if (ack != 0 && res_valid) overlap++;
      end while (ack == 0 && n < 20);
      check($sformatf("t3_grant%0d", g), 256'(ack), 256'(exp_ack));
      if (g == 4) req = '0;
      n = 0;
      do begin
        tick; n++;
        if (ack != 0 && res_valid) overlap++;
      end while (!res_valid && n < 20);
      check($sformatf("t3_res_axis%0d", g), 256'({res_valid, res_axis}), 256'({1'b1, 2'(g % 4)}));
    end
    check("t3_no_overlap", 256'(overlap), 256'(0));
    n = 0;
    do begin tick; n++; end while (busy && n < 20);
    check("t3_idle", 256'(busy), 256'(0));

    // Timeout on axis1 (pointer now 1)
    mode_never = 1'b1;
    req = 4'b0010;
    tick;
    check("t4_ack", 256'(ack), 256'(4'b0010));
    req = '0;
    tick;
    check("t4_start", 256'(calc_start), 256'(1));
    n = 0;
    do begin tick; n++; end while (!res_valid && n < 100);
    check("t4_cycles", 256'(n), 256'(64));
    check("t4_err", 256'(res_err), 256'(1));
    check("t4_data", 256'(res_data), 256'(0));
    check("t4_axis", 256'(res_axis), 256'(1));
    tick;
    check("t4_start_low", 256'(calc_start), 256'(0));
    check("t4_idle", 256'(busy), 256'(0));
    mode_never = 1'b0;

    // Release handshake: finish held 3 extra cycles, req1 pending meanwhile
    hold_extra = 3;
    req = 4'b0100;
    tick;                                          // E0
    check("t5_ack2", 256'(ack), 256'(4'b0100));
    req = 4'b0010;
    tick; tick; tick;                              // E3
    check("t5_vld", 256'({res_valid, res_axis}), 256'({1'b1, 2'd2}));
    for (int k = 1; k <= 5; k++) begin             // E4..E8
      tick;
      check($sformatf("t5_no_ack_k%0d", k), 256'(ack), 256'(0));
      if (k == 4) check("t5_busy_rel", 256'(busy), 256'(1));
    end
    tick;                                          // E9
    check("t5_ack1", 256'(ack), 256'(4'b0010));
    req = '0;
    n = 0;
    do begin tick; n++; end while (!res_valid && n < 20);
    check("t5_res1", 256'({res_valid, res_err, res_axis}), 256'({1'b1, 1'b0, 2'd1}));
    check("t5_data1", 256'(res_data), 256'(AX1_RES));
    n = 0;
    do begin tick; n++; end while (busy && n < 20);
    check("t5_idle", 256'(busy), 256'(0));
    hold_extra = 0;

    // Reset while axis1 is in WAIT; req1 stays high across reset
    mode_never = 1'b1;
    req = 4'b0010;
    tick;
    check("t6_ack", 256'(ack), 256'(4'b0010));
    tick;
    check("t6_start", 256'(calc_start), 256'(1));
    tick; tick; tick;
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_start", 256'(calc_start), 256'(0));
    check("t6_rst_busy", 256'(busy), 256'(0));
    check("t6_rst_vld", 256'({res_valid, ack}), 256'(0));
    mode_never = 1'b0;
    #2;
    reset = 1'b1;
    n = 0;
    do begin tick; n++; end while (ack == 0 && n < 20);
    check("t6_reack", 256'(ack), 256'(4'b0010));
    req = '0;
    n = 0;
    do begin tick; n++; end while (!res_valid && n < 20);
    check("t6_res", 256'({res_valid, res_err, res_axis}), 256'({1'b1, 1'b0, 2'd1}));
    check("t6_data", 256'(res_data), 256'(AX1_RES));
    n = 0;
    do begin tick; n++; end while (busy && n < 20);
    check("t6_idle", 256'(busy), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
